// File: rtl/order_input_arbiter.sv
// order_input_arbiter: merges network orders, bot orders and dump commands into one engine issue stream.
// Statistics counters are built only when ORDER_ARB_STATS_EN is defined; otherwise they read zero.
module order_input_arbiter #(
    parameter int BOT_MAX_WAIT = 8,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       net_dout,
    input  logic              net_empty,
    output logic              net_rd_en,
    input  logic [31:0]       bot_dout,
    input  logic              bot_empty,
    output logic              bot_rd_en,
    input  logic              dump_req,
    input  logic              engine_busy,
    output logic              ob_valid,
    output logic [31:0]       ob_data,
    output logic              ob_src,
    output logic              ob_dump,
    output logic [STAT_W-1:0] net_grant_cnt,
    output logic [STAT_W-1:0] bot_grant_cnt,
    output logic [STAT_W-1:0] nop_drop_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, GUARD} state_t;
    localparam logic [7:0] MAXW = 8'(BOT_MAX_WAIT);

    state_t      state_q, state_d;
    logic        dump_pending_q, dump_pending_d;
    logic [7:0]  starve_q, starve_d;
    logic        ob_valid_q, ob_src_q, ob_dump_q;
    logic [31:0] ob_data_q;
    logic        can_grant, bot_starved, g_dump, g_bot, g_net, is_nop, order_issue;

    // Grants are gated by rst_n so no FIFO pops while reset is held.
    always_comb begin
        can_grant      = rst_n && state_q == IDLE && !engine_busy;
        bot_starved    = starve_q == MAXW && !bot_empty;
        g_dump         = can_grant && dump_pending_q;
        g_bot          = can_grant && !dump_pending_q && !bot_empty && (bot_starved || net_empty);
        g_net          = can_grant && !dump_pending_q && !net_empty && !bot_starved;
        is_nop         = g_net && net_dout == 32'h0;
        order_issue    = g_bot || (g_net && !is_nop);
        net_rd_en      = g_net;
        bot_rd_en      = g_bot;
        state_d        = state_q == IDLE  ? ((g_dump || order_issue) ? ISSUE : IDLE)
                       : state_q == ISSUE ? GUARD : IDLE;
        dump_pending_d = dump_req || (dump_pending_q && !g_dump);
        starve_d       = (bot_empty || g_bot) ? 8'd0
                       : (g_net && starve_q != MAXW) ? starve_q + 8'd1 : starve_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            dump_pending_q <= 1'b0;
            starve_q       <= 8'd0;
            ob_valid_q     <= 1'b0;
            ob_src_q       <= 1'b0;
            ob_dump_q      <= 1'b0;
            ob_data_q      <= 32'h0;
        end else begin
            state_q        <= state_d;
            dump_pending_q <= dump_pending_d;
            starve_q       <= starve_d;
            ob_valid_q     <= order_issue;
            ob_src_q       <= g_bot;
            ob_dump_q      <= g_dump;
            ob_data_q      <= order_issue ? (g_bot ? bot_dout : net_dout) : ob_data_q;
        end
    end

    assign ob_valid = ob_valid_q;
    assign ob_src   = ob_src_q;
    assign ob_dump  = ob_dump_q;
    assign ob_data  = ob_data_q;

`ifdef ORDER_ARB_STATS_EN
    logic [STAT_W-1:0] net_cnt_q, bot_cnt_q, nop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            net_cnt_q <= '0;
            bot_cnt_q <= '0;
            nop_cnt_q <= '0;
        end else begin
            if (g_net && !is_nop && !(&net_cnt_q)) net_cnt_q <= net_cnt_q + STAT_W'(1);
            if (g_bot && !(&bot_cnt_q)) bot_cnt_q <= bot_cnt_q + STAT_W'(1);
            if (is_nop && !(&nop_cnt_q)) nop_cnt_q <= nop_cnt_q + STAT_W'(1);
        end
    end

    assign net_grant_cnt = net_cnt_q;
    assign bot_grant_cnt = bot_cnt_q;
    assign nop_drop_cnt  = nop_cnt_q;
`else
    assign net_grant_cnt = '0;
    assign bot_grant_cnt = '0;
    assign nop_drop_cnt  = '0;
`endif
endmodule

// File: tb/tb_order_input_arbiter.sv
// tb_order_input_arbiter: randomized and directed scoreboard bench for order_input_arbiter.
module tb_order_input_arbiter;
    localparam int MAX = 8;
    localparam int SW  = 16;

    typedef struct {
        bit          dump;
        logic [31:0] data;
        bit          src;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   net_dout, bot_dout, ob_data;
    logic          net_empty, bot_empty, net_rd_en, bot_rd_en;
    logic          dump_req, engine_busy, ob_valid, ob_src, ob_dump;
    logic [SW-1:0] net_grant_cnt, bot_grant_cnt, nop_drop_cnt;

    logic [31:0] netq[$];
    logic [31:0] botq[$];
    exp_t        sbq[$];
    int          vec = 0, errs = 0, cyc = 0;
    int          m_cool = 0, m_starve = 0, m_net = 0, m_bot = 0, m_nop = 0;
    bit          m_dump = 0;

    order_input_arbiter #(.BOT_MAX_WAIT(MAX), .STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .net_dout(net_dout), .net_empty(net_empty), .net_rd_en(net_rd_en),
        .bot_dout(bot_dout), .bot_empty(bot_empty), .bot_rd_en(bot_rd_en),
        .dump_req(dump_req), .engine_busy(engine_busy),
        .ob_valid(ob_valid), .ob_data(ob_data), .ob_src(ob_src), .ob_dump(ob_dump),
        .net_grant_cnt(net_grant_cnt), .bot_grant_cnt(bot_grant_cnt), .nop_drop_cnt(nop_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef ORDER_ARB_STATS_EN
        check("net_grant_cnt", 32'(net_grant_cnt), m_net);
        check("bot_grant_cnt", 32'(bot_grant_cnt), m_bot);
        check("nop_drop_cnt", 32'(nop_drop_cnt), m_nop);
`else
        check("net_grant_cnt", 32'(net_grant_cnt), 0);
        check("bot_grant_cnt", 32'(bot_grant_cnt), 0);
        check("nop_drop_cnt", 32'(nop_drop_cnt), 0);
`endif
    endtask

    task automatic drive_fifo();
        net_empty = netq.size() == 0;
        bot_empty = botq.size() == 0;
        net_dout  = net_empty ? 32'hDEADBEEF : netq[0];
        bot_dout  = bot_empty ? 32'hDEADBEEF : botq[0];
    endtask

    task automatic model_reset();
        m_cool = 0; m_starve = 0; m_dump = 0;
        m_net = 0; m_bot = 0; m_nop = 0;
    endtask

    // One clock: called just after a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        int          g;
        bit          bempty, issued;
        logic [31:0] tmp;
        exp_t        e;
        drive_fifo();
        #1;
        g = 0;
        if (m_cool == 0 && !engine_busy) begin
            if (m_dump) g = 1;
            else if (m_starve == MAX && botq.size() != 0) g = 2;
            else if (netq.size() != 0) g = 3;
            else if (botq.size() != 0) g = 2;
        end
        check("net_rd_en", 32'(net_rd_en), 32'(g == 3));
        check("bot_rd_en", 32'(bot_rd_en), 32'(g == 2));
        if (g == 1) begin e.dump = 1; e.data = 0; e.src = 0; e.cyc = cyc + 1; sbq.push_back(e); end
        if (g == 2) begin e.dump = 0; e.data = botq[0]; e.src = 1; e.cyc = cyc + 1; sbq.push_back(e); end
        if (g == 3 && netq[0] != 0) begin e.dump = 0; e.data = netq[0]; e.src = 0; e.cyc = cyc + 1; sbq.push_back(e); end
        @(posedge clk);
        bempty = botq.size() == 0;
        issued = g == 1 || g == 2 || (g == 3 && netq[0] != 0);
        if (g == 3) begin
            if (netq[0] == 0) m_nop++; else m_net++;
            tmp = netq.pop_front();
        end
        if (g == 2) begin
            m_bot++;
            tmp = botq.pop_front();
        end
        m_dump   = dump_req || (m_dump && g != 1);
        m_starve = (bempty || g == 2) ? 0 : (g == 3) ? ((m_starve < MAX) ? m_starve + 1 : MAX) : m_starve;
        m_cool   = issued ? 2 : (m_cool > 0 ? m_cool - 1 : 0);
        cyc++;
        @(negedge clk);
        dump_req = 1'b0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Scoreboard monitor: every strobe must match the head of the expectation queue for this cycle.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (rst_n) begin
            if (ob_valid && ob_dump) check("valid_dump_exclusive", 32'(1), 32'(0));
            if (ob_valid || ob_dump) begin
                if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
                    vec++; errs++;
                    $display("FAIL unexpected_strobe at cycle %0d: valid=%b dump=%b data=%h, none expected", cyc, ob_valid, ob_dump, ob_data);
                end else begin
                    e = sbq.pop_front();
                    check("ob_dump", 32'(ob_dump), 32'(e.dump));
                    check("ob_valid", 32'(ob_valid), 32'(!e.dump));
                    check("ob_src", 32'(ob_src), 32'(e.src));
                    if (!e.dump) check("ob_data", ob_data, e.data);
                end
            end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                vec++; errs++;
                $display("FAIL missing_strobe at cycle %0d: got none expected dump=%b data=%h", cyc, e.dump, e.data);
            end
        end
    end

    initial begin
        rst_n = 1'b0; dump_req = 1'b0; engine_busy = 1'b0;
        netq.push_back(32'h00010064);
        drive_fifo();
        #2;
        check("reset_net_rd_en", 32'(net_rd_en), 0);
        check("reset_ob_valid", 32'(ob_valid), 0);
        check("reset_ob_dump", 32'(ob_dump), 0);
        check("reset_ob_data", ob_data, 0);
        chk_stats();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run(6);
        netq.push_back(32'h0); netq.push_back(32'h00020032);
        run(8);
        chk_stats();
        for (int i = 0; i < 20; i++) netq.push_back(32'hA0000000 + i);
        botq.push_back(32'hB0000001);
        run(80);
        chk_stats();
        engine_busy = 1'b1;
        netq.push_back(32'h00030001);
        for (int i = 0; i < 3; i++) begin dump_req = 1'b1; run(3); end
        engine_busy = 1'b0;
        run(8);
        dump_req = 1'b1; cycle();
        dump_req = 1'b1; cycle();
        run(10);
        engine_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin netq.push_back(32'h00040000 + i); botq.push_back(32'hB0000010 + i); end
        run(50);
        engine_busy = 1'b0;
        run(30);
        netq.push_back(32'h12345678);
        cycle();
        rst_n = 1'b0;
        #1;
        check("abort_ob_valid", 32'(ob_valid), 0);
        check("abort_ob_src", 32'(ob_src), 0);
        check("abort_ob_data", ob_data, 0);
        check("abort_net_rd_en", 32'(net_rd_en), 0);
        model_reset();
        chk_stats();
        @(posedge clk); cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        run(5);
        netq.push_back(32'h00050005);
        run(5);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) netq.push_back($urandom_range(0, 3) == 0 ? 32'h0 : $urandom);
            if ($urandom_range(0, 5) == 0) botq.push_back($urandom);
            dump_req    = $urandom_range(0, 24) == 0;
            engine_busy = $urandom_range(0, 4) == 0;
            cycle();
        end
        engine_busy = 1'b0;
        for (int i = 0; i < 2000 && (netq.size() != 0 || botq.size() != 0 || m_dump); i++) cycle();
        run(5);
        chk_stats();
        check("fifos_drained", netq.size() + botq.size(), 0);
        check("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
